// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the multicycle RV32 control path.
// Holds the opcode values, FSM state encoding, instruction classes and the
// aluOp / immSel / pcSrc control codes used by multicycle_control and instr_class_dec.
package riscv_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Encoding is visible on the debug state port, so values are fixed.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CLS_OP      = 3'd0,
      CLS_OPIMM   = 3'd1,
      CLS_LOAD    = 3'd2,
      CLS_STORE   = 3'd3,
      CLS_BRANCH  = 3'd4,
      CLS_ILLEGAL = 3'd5
   } instr_class_t;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;

endpackage

// File: rtl/instr_class_dec.sv
// instr_class_dec: combinational instruction classifier.
// Ports: instr (32b IR contents) in; cls (OP/OPIMM/LOAD/STORE/BRANCH/ILLEGAL) out.
// Only opcode and funct3 are inspected; any unsupported combination is ILLEGAL.
module instr_class_dec
   import riscv_pkg::*;
(
   input  logic [31:0]  instr,
   output instr_class_t cls
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign unused_bits = ^{instr[31:15], instr[11:7]};

   always_comb begin
      cls = CLS_ILLEGAL;
      case (opcode)
         OPC_OP:     if (funct3 == 3'b000) cls = CLS_OP;
         OPC_OPIMM:  if (funct3 == 3'b000) cls = CLS_OPIMM;
         OPC_LOAD:   if (funct3 == 3'b010) cls = CLS_LOAD;
         OPC_STORE:  if (funct3 == 3'b010) cls = CLS_STORE;
         OPC_BRANCH: if (funct3[2:1] == 2'b00) cls = CLS_BRANCH;
         default:    cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing a multicycle RV32 subset datapath.
// Ports: clk, rst_n (async active-low); instr/zero/memReady in; memory, IR/PC, ALU,
// writeback strobes, debug state, halt/busErr out. Define INSTR_CNT_EN to add instrCnt.
module multicycle_control
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        memReady,
   output logic        memReq,
   output logic        memWe,
   output logic        memSel,
   output logic        irWrite,
   output logic        pcWrite,
   output logic [1:0]  pcSrc,
   output logic [1:0]  immSel,
   output logic        aluSrcB,
   output logic [1:0]  aluOp,
   output logic        regWrite,
   output logic        memToReg,
   output logic [2:0]  state,
   output logic        halt,
   output logic        busErr
`ifdef INSTR_CNT_EN
   ,
   output logic [31:0] instrCnt
`endif
);

   // Counter only has to reach TIMEOUT_CYCLES-1 before the halting transition.
   localparam int unsigned WCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t       state_q, state_nxt;
   instr_class_t dec_cls, cls_q;
   logic [WCW-1:0] wait_cnt, wait_nxt;
   logic         bus_err_q;
   logic         timeout_hit;
   logic         timeout_take;

   instr_class_dec u_dec (
      .instr (instr),
      .cls   (dec_cls)
   );

   assign state = state_q;

   // Fires on the not-ready cycle that would bring the count up to TIMEOUT_CYCLES.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                        (32'(wait_cnt) == TIMEOUT_CYCLES - 32'd1);

   always_comb begin
      state_nxt    = state_q;
      timeout_take = 1'b0;
      memReq       = 1'b0;
      memWe        = 1'b0;
      memSel       = 1'b0;
      irWrite      = 1'b0;
      pcWrite      = 1'b0;
      pcSrc        = PC_PLUS4;
      immSel       = IMM_I;
      aluSrcB      = 1'b0;
      aluOp        = ALU_ADD;
      regWrite     = 1'b0;
      memToReg     = 1'b0;
      halt         = 1'b0;
      busErr       = 1'b0;
      case (state_q)
         S_IDLE: state_nxt = S_FETCH;
         S_FETCH: begin
            memReq = 1'b1;
            memSel = 1'b0;
            if (memReady) begin
               irWrite   = 1'b1;
               pcWrite   = 1'b1;
               pcSrc     = PC_PLUS4;
               state_nxt = S_DECODE;
            end else if (timeout_hit) begin
               timeout_take = 1'b1;
               state_nxt    = S_HALT;
            end
         end
         S_DECODE: state_nxt = (dec_cls == CLS_ILLEGAL) ? S_HALT : S_EXEC;
         S_EXEC: begin
            case (cls_q)
               CLS_OP, CLS_OPIMM: begin
                  aluOp     = ALU_FUNCT;
                  aluSrcB   = (cls_q == CLS_OPIMM);
                  immSel    = IMM_I;
                  state_nxt = S_WB;
               end
               CLS_LOAD, CLS_STORE: begin
                  aluOp     = ALU_ADD;
                  aluSrcB   = 1'b1;
                  immSel    = (cls_q == CLS_STORE) ? IMM_S : IMM_I;
                  state_nxt = S_MEM;
               end
               CLS_BRANCH: begin
                  aluOp   = ALU_SUB;
                  aluSrcB = 1'b0;
                  immSel  = IMM_B;
                  // funct3[0] inverts the sense: BEQ takes on zero, BNE on non-zero.
                  if (zero ^ instr[12]) begin
                     pcWrite = 1'b1;
                     pcSrc   = PC_BRANCH;
                  end
                  state_nxt = S_FETCH;
               end
               default: state_nxt = S_HALT;
            endcase
         end
         S_MEM: begin
            // Address stays on the ALU result, so the EXEC controls are held.
            memReq  = 1'b1;
            memSel  = 1'b1;
            memWe   = (cls_q == CLS_STORE);
            aluOp   = ALU_ADD;
            aluSrcB = 1'b1;
            immSel  = (cls_q == CLS_STORE) ? IMM_S : IMM_I;
            if (memReady) begin
               state_nxt = (cls_q == CLS_STORE) ? S_FETCH : S_WB;
            end else if (timeout_hit) begin
               timeout_take = 1'b1;
               state_nxt    = S_HALT;
            end
         end
         S_WB: begin
            regWrite  = 1'b1;
            memToReg  = (cls_q == CLS_LOAD);
            state_nxt = S_FETCH;
         end
         S_HALT: begin
            halt   = 1'b1;
            busErr = bus_err_q;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      wait_nxt = '0;
      if ((state_q == S_FETCH || state_q == S_MEM) && !memReady && state_nxt == state_q)
         wait_nxt = wait_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cls_q     <= CLS_OP;
         wait_cnt  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         wait_cnt  <= wait_nxt;
         bus_err_q <= bus_err_q | timeout_take;
         if (state_q == S_DECODE)
            cls_q <= dec_cls;
      end
   end

`ifdef INSTR_CNT_EN
   logic retire;
   assign retire = (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) &&
                   (state_nxt == S_FETCH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         instrCnt <= '0;
      else if (retire)
         instrCnt <= instrCnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control.
// Each cycle pushes an expected output vector to a scoreboard and pops it once
// the DUT outputs have settled; optional instrCnt checked when INSTR_CNT_EN is defined.
module tb_multicycle_control;

   typedef struct packed {
      logic [2:0] st;
      logic       mreq, mwe, msel, irw, pcw;
      logic [1:0] pcs, ims;
      logic       asb;
      logic [1:0] aop;
      logic       rw, m2r, hlt, berr;
   } outs_t;

   typedef struct {
      string tag;
      outs_t v;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        zero = 1'b0;
   logic        memReady = 1'b0;
   logic        memReq, memWe, memSel, irWrite, pcWrite;
   logic [1:0]  pcSrc, immSel, aluOp;
   logic        aluSrcB, regWrite, memToReg, halt, busErr;
   logic [2:0]  state;
`ifdef INSTR_CNT_EN
   logic [31:0] instrCnt;
   logic [31:0] exp_cnt = 32'd0;
`endif

   int    n_cmp = 0;
   int    n_err = 0;
   exp_t  sb[$];
   outs_t obs;

   always #5 clk = ~clk;

   multicycle_control #(.TIMEOUT_CYCLES(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .instr    (instr),
      .zero     (zero),
      .memReady (memReady),
      .memReq   (memReq),
      .memWe    (memWe),
      .memSel   (memSel),
      .irWrite  (irWrite),
      .pcWrite  (pcWrite),
      .pcSrc    (pcSrc),
      .immSel   (immSel),
      .aluSrcB  (aluSrcB),
      .aluOp    (aluOp),
      .regWrite (regWrite),
      .memToReg (memToReg),
      .state    (state),
      .halt     (halt),
      .busErr   (busErr)
`ifdef INSTR_CNT_EN
      ,
      .instrCnt (instrCnt)
`endif
   );

   assign obs = {state, memReq, memWe, memSel, irWrite, pcWrite, pcSrc, immSel,
                 aluSrcB, aluOp, regWrite, memToReg, halt, busErr};

   // Expected-output model, one function per FSM state.
   function automatic outs_t e_idle();
      outs_t e = '0;
      return e;
   endfunction
   function automatic outs_t e_fetch(input logic rdy);
      outs_t e = '0;
      e.st = 3'd1; e.mreq = 1'b1;
      if (rdy) begin e.irw = 1'b1; e.pcw = 1'b1; e.pcs = 2'b00; end
      return e;
   endfunction
   function automatic outs_t e_decode();
      outs_t e = '0;
      e.st = 3'd2;
      return e;
   endfunction
   function automatic outs_t e_exop(input logic opimm);
      outs_t e = '0;
      e.st = 3'd3; e.aop = 2'b10; e.asb = opimm; e.ims = 2'b00;
      return e;
   endfunction
   function automatic outs_t e_exls(input logic store);
      outs_t e = '0;
      e.st = 3'd3; e.aop = 2'b00; e.asb = 1'b1; e.ims = store ? 2'b01 : 2'b00;
      return e;
   endfunction
   function automatic outs_t e_exbr(input logic take);
      outs_t e = '0;
      e.st = 3'd3; e.aop = 2'b01; e.ims = 2'b10;
      if (take) begin e.pcw = 1'b1; e.pcs = 2'b01; end
      return e;
   endfunction
   function automatic outs_t e_mem(input logic store);
      outs_t e = '0;
      e.st = 3'd4; e.mreq = 1'b1; e.msel = 1'b1; e.mwe = store;
      e.aop = 2'b00; e.asb = 1'b1; e.ims = store ? 2'b01 : 2'b00;
      return e;
   endfunction
   function automatic outs_t e_wb(input logic load);
      outs_t e = '0;
      e.st = 3'd5; e.rw = 1'b1; e.m2r = load;
      return e;
   endfunction
   function automatic outs_t e_halt(input logic be);
      outs_t e = '0;
      e.st = 3'd6; e.hlt = 1'b1; e.berr = be;
      return e;
   endfunction

   task automatic chk(input string tag, input outs_t e);
      exp_t x;
      x.tag = tag;
      x.v   = e;
      sb.push_back(x);
      #1;
      x = sb.pop_front();
      n_cmp++;
      assert (obs === x.v) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.v);
      end
   endtask

   task automatic cyc(input string tag, input outs_t e, input logic rdy, input logic z);
      @(negedge clk);
      memReady = rdy;
      zero     = z;
      chk(tag, e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      memReady = 1'b0;
      zero     = 1'b0;
      instr    = 32'h0;
      chk("rst_hold", e_idle());
`ifdef INSTR_CNT_EN
      exp_cnt = 32'd0;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_idle", e_idle());
   endtask

   task automatic fetch(input string tag, input logic [31:0] ins, input int waits);
      for (int i = 0; i <= waits; i++) begin
         @(negedge clk);
         instr    = ins;
         memReady = (i == waits);
         zero     = 1'b0;
         chk(tag, e_fetch(i == waits));
`ifdef INSTR_CNT_EN
         if (i == 0) begin
            n_cmp++;
            assert (instrCnt === exp_cnt) else begin
               n_err++;
               $error("FAIL %s_cnt observed=%0d expected=%0d", tag, instrCnt, exp_cnt);
            end
         end
`endif
      end
   endtask

   task automatic retired();
`ifdef INSTR_CNT_EN
      exp_cnt = exp_cnt + 32'd1;
`endif
   endtask

   initial begin
      do_reset();

      // ADDI x1,x0,7: FETCH, DECODE, EXEC, WB, then FETCH again after 4 cycles.
      fetch("addi_f", 32'h00700093, 0);
      cyc("addi_d", e_decode(), 1'b1, 1'b0);   // memReady ignored without memReq
      cyc("addi_x", e_exop(1'b1), 1'b0, 1'b0);
      cyc("addi_wb", e_wb(1'b0), 1'b0, 1'b0);
      retired();

      // LW with two fetch wait states and three MEM wait states.
      fetch("lw_f", 32'h00002103, 2);
      cyc("lw_d", e_decode(), 1'b0, 1'b0);
      cyc("lw_x", e_exls(1'b0), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc("lw_mwait", e_mem(1'b0), 1'b0, 1'b0);
      cyc("lw_macc", e_mem(1'b0), 1'b1, 1'b0);
      cyc("lw_wb", e_wb(1'b1), 1'b0, 1'b0);
      retired();

      // SW: no WB, straight back to FETCH.
      fetch("sw_f", 32'h00102223, 0);
      cyc("sw_d", e_decode(), 1'b0, 1'b0);
      cyc("sw_x", e_exls(1'b1), 1'b0, 1'b0);
      cyc("sw_m", e_mem(1'b1), 1'b1, 1'b0);
      retired();

      // BNE taken when zero=0, not taken when zero=1.
      fetch("bne0_f", 32'h00419463, 0);
      cyc("bne0_d", e_decode(), 1'b0, 1'b0);
      cyc("bne0_x", e_exbr(1'b1), 1'b0, 1'b0);
      retired();
      fetch("bne1_f", 32'h00419463, 0);
      cyc("bne1_d", e_decode(), 1'b0, 1'b1);
      cyc("bne1_x", e_exbr(1'b0), 1'b0, 1'b1);
      retired();

      // BEQ taken when zero=1.
      fetch("beq_f", 32'h00208463, 0);
      cyc("beq_d", e_decode(), 1'b0, 1'b1);
      cyc("beq_x", e_exbr(1'b1), 1'b0, 1'b1);
      retired();

      // ADD (register-register).
      fetch("add_f", 32'h002081B3, 0);
      cyc("add_d", e_decode(), 1'b0, 1'b0);
      cyc("add_x", e_exop(1'b0), 1'b0, 1'b0);
      cyc("add_wb", e_wb(1'b0), 1'b0, 1'b0);
      retired();

      // Illegal encoding halts after DECODE without bus error, and stays halted.
      fetch("ill_f", 32'hFFFFFFFF, 0);
      cyc("ill_d", e_decode(), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc("ill_halt", e_halt(1'b0), 1'b1, 1'b0);
`ifdef INSTR_CNT_EN
      n_cmp++;
      assert (instrCnt === exp_cnt) else begin
         n_err++;
         $error("FAIL halt_cnt observed=%0d expected=%0d", instrCnt, exp_cnt);
      end
`endif

      // LB (unsupported funct3 for LOAD) is illegal too.
      do_reset();
      fetch("lb_f", 32'h00000003, 0);
      cyc("lb_d", e_decode(), 1'b0, 1'b0);
      cyc("lb_halt", e_halt(1'b0), 1'b0, 1'b0);

      // Fetch timeout: 16 not-ready FETCH cycles, then HALT with busErr.
      do_reset();
      for (int i = 0; i < 16; i++) cyc("to_fwait", e_fetch(1'b0), 1'b0, 1'b0);
      cyc("to_halt", e_halt(1'b1), 1'b1, 1'b0);
      cyc("to_hold", e_halt(1'b1), 1'b0, 1'b0);

      // Asynchronous reset in the middle of a MEM request.
      do_reset();
      fetch("ar_f", 32'h00002103, 0);
      cyc("ar_d", e_decode(), 1'b0, 1'b0);
      cyc("ar_x", e_exls(1'b0), 1'b0, 1'b0);
      cyc("ar_m", e_mem(1'b0), 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      chk("ar_async", e_idle());
`ifdef INSTR_CNT_EN
      exp_cnt = 32'd0;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      chk("ar_idle", e_idle());
      fetch("ar_refetch", 32'h00700093, 0);
      cyc("ar_d2", e_decode(), 1'b0, 1'b0);
      cyc("ar_x2", e_exop(1'b1), 1'b0, 1'b0);
      cyc("ar_wb2", e_wb(1'b0), 1'b0, 1'b0);
      retired();
      fetch("ar_next", 32'h00700093, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
